// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : shared datapath defaults and ALU flag indices             |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
package cpu_pkg;
  localparam int C_DATA_W     = 8;
  localparam int C_ADDR_W     = 32;
  localparam int C_DMEM_DEPTH = 256;

  // Bit positions of the ALU flags when packed into one vector
  localparam int C_FLAG_ZR    = 0;
  localparam int C_FLAG_NG    = 1;
  localparam int C_FLAG_CR    = 2;
  localparam int C_FLAG_OV    = 3;
  localparam int C_NUM_FLAGS  = 4;
endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem : data memory, synchronous write / asynchronous read       |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module data_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int DEPTH  = C_DMEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents deliberately carry no reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];
endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage : data memory access, branch resolve, MEM/WB register     |
// | Option macro MEM_STAGE_STORE_CNT_EN adds the store_count output.    |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = C_DATA_W,
  parameter int ADDR_W     = C_ADDR_W,
  parameter int DMEM_DEPTH = C_DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] MEM_aluout,
  input  logic [DATA_W-1:0] MEM_read_data_2,
  input  logic [ADDR_W-1:0] MEM_reg_write_addr,
  input  logic [ADDR_W-1:0] MEM_branch_addr,
  input  logic [ADDR_W-1:0] MEM_jump_addr,
  input  logic              MEM_zr,
  input  logic              MEM_ng,
  input  logic              MEM_cr,
  input  logic              MEM_ov,
  input  logic              MEM_Branch,
  input  logic              MEM_BranchFlip,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_Jump,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemtoReg,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic [DATA_W-1:0] WB_read_data,
  output logic [DATA_W-1:0] WB_aluout,
  output logic [ADDR_W-1:0] WB_reg_write_addr,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic [DATA_W-1:0] WB_write_data
`ifdef MEM_STAGE_STORE_CNT_EN
  ,
  output logic [15:0]       store_count
`endif
);
  localparam int c_IDX_W = $clog2(DMEM_DEPTH);

  logic [C_NUM_FLAGS-1:0] w_flags;
  logic                   w_unused_flags;
  logic                   w_branch_taken;
  logic                   w_store;
  logic [DATA_W-1:0]      w_mem_rdata;
  logic [DATA_W-1:0]      w_rdata;

  always_comb begin
    w_flags            = '0;
    w_flags[C_FLAG_ZR] = MEM_zr;
    w_flags[C_FLAG_NG] = MEM_ng;
    w_flags[C_FLAG_CR] = MEM_cr;
    w_flags[C_FLAG_OV] = MEM_ov;
  end

  // Only the zero flag participates in branch resolution
  assign w_unused_flags = ^{w_flags[C_FLAG_NG], w_flags[C_FLAG_CR], w_flags[C_FLAG_OV]};

  assign w_branch_taken = MEM_Branch & (w_flags[C_FLAG_ZR] ^ MEM_BranchFlip);
  assign pc_redirect    = ~rst & (MEM_Jump | w_branch_taken);
  assign flush          = pc_redirect;

  always_comb begin
    pc_target = '0;
    if (pc_redirect) begin
      pc_target = MEM_Jump ? MEM_jump_addr : MEM_branch_addr;
    end
  end

  assign w_store = MEM_MemWrite & ~rst;

  data_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DMEM_DEPTH)
  ) u_data_mem (
    .clk     (clk),
    .i_we    (w_store),
    .i_addr  (MEM_aluout[c_IDX_W-1:0]),
    .i_wdata (MEM_read_data_2),
    .o_rdata (w_mem_rdata)
  );

  assign w_rdata = MEM_MemRead ? w_mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      WB_read_data      <= '0;
      WB_aluout         <= '0;
      WB_reg_write_addr <= '0;
      WB_RegWrite       <= 1'b0;
      WB_MemtoReg       <= 1'b0;
    end else begin
      WB_read_data      <= w_rdata;
      WB_aluout         <= MEM_aluout;
      WB_reg_write_addr <= MEM_reg_write_addr;
      WB_RegWrite       <= MEM_RegWrite;
      WB_MemtoReg       <= MEM_MemtoReg;
    end
  end

  assign WB_write_data = WB_MemtoReg ? WB_read_data : WB_aluout;

`ifdef MEM_STAGE_STORE_CNT_EN
  logic [15:0] r_store_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_store_count <= '0;
    end else if (w_store) begin
      r_store_count <= r_store_count + 16'd1;
    end
  end

  assign store_count = r_store_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_stage : randomized self-checking bench for mem_stage         |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module tb_mem_stage;
  localparam int DW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] MEM_aluout, MEM_read_data_2;
  logic [AW-1:0] MEM_reg_write_addr, MEM_branch_addr, MEM_jump_addr;
  logic          MEM_zr, MEM_ng, MEM_cr, MEM_ov;
  logic          MEM_Branch, MEM_BranchFlip, MEM_MemRead, MEM_MemWrite;
  logic          MEM_Jump, MEM_RegWrite, MEM_MemtoReg;
  logic          pc_redirect, flush;
  logic [AW-1:0] pc_target;
  logic [DW-1:0] WB_read_data, WB_aluout, WB_write_data;
  logic [AW-1:0] WB_reg_write_addr;
  logic          WB_RegWrite, WB_MemtoReg;
`ifdef MEM_STAGE_STORE_CNT_EN
  logic [15:0]   store_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] ref_mem [256];

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(DW), .ADDR_W(AW), .DMEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .MEM_aluout(MEM_aluout), .MEM_read_data_2(MEM_read_data_2),
    .MEM_reg_write_addr(MEM_reg_write_addr), .MEM_branch_addr(MEM_branch_addr),
    .MEM_jump_addr(MEM_jump_addr),
    .MEM_zr(MEM_zr), .MEM_ng(MEM_ng), .MEM_cr(MEM_cr), .MEM_ov(MEM_ov),
    .MEM_Branch(MEM_Branch), .MEM_BranchFlip(MEM_BranchFlip),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Jump(MEM_Jump), .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush(flush),
    .WB_read_data(WB_read_data), .WB_aluout(WB_aluout),
    .WB_reg_write_addr(WB_reg_write_addr), .WB_RegWrite(WB_RegWrite),
    .WB_MemtoReg(WB_MemtoReg), .WB_write_data(WB_write_data)
`ifdef MEM_STAGE_STORE_CNT_EN
    , .store_count(store_count)
`endif
  );

  task automatic idle();
    rst = 1'b0;
    MEM_aluout = '0; MEM_read_data_2 = '0;
    MEM_reg_write_addr = '0; MEM_branch_addr = '0; MEM_jump_addr = '0;
    {MEM_zr, MEM_ng, MEM_cr, MEM_ov} = '0;
    {MEM_Branch, MEM_BranchFlip, MEM_MemRead, MEM_MemWrite} = '0;
    {MEM_Jump, MEM_RegWrite, MEM_MemtoReg} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store one byte and mirror it in the model
  task automatic store(input logic [7:0] a, input logic [7:0] d);
    idle();
    MEM_MemWrite = 1'b1; MEM_aluout = a; MEM_read_data_2 = d;
    tick();
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; MEM_Jump = 1'b1; MEM_jump_addr = 32'h1234; MEM_RegWrite = 1'b1;
    MEM_aluout = 8'h5A; MEM_MemtoReg = 1'b1;
    #1;
    n_vec++;
    if ({pc_redirect, flush, pc_target} !== '0) begin
      n_err++; $display("FAIL reset_redirect: got %b/%b/%h want 0/0/0", pc_redirect, flush, pc_target);
    end
    tick(); tick();
    n_vec++;
    if ({WB_read_data, WB_aluout, WB_reg_write_addr, WB_RegWrite, WB_MemtoReg} !== '0) begin
      n_err++; $display("FAIL reset_wb: got rd=%h alu=%h ra=%h rw=%b m2r=%b want all 0",
                        WB_read_data, WB_aluout, WB_reg_write_addr, WB_RegWrite, WB_MemtoReg);
    end
    idle();
    for (int i = 0; i < 256; i++) store(i[7:0], 8'($urandom));
  endtask

  task automatic test_store_load();
    store(8'h10, 8'hA5);
    idle();
    MEM_MemRead = 1'b1; MEM_aluout = 8'h10; MEM_MemtoReg = 1'b1;
    MEM_RegWrite = 1'b1; MEM_reg_write_addr = 32'd7;
    tick();
    n_vec++;
    if (WB_write_data !== 8'hA5 || WB_RegWrite !== 1'b1 || WB_reg_write_addr !== 32'd7) begin
      n_err++; $display("FAIL store_load: got wd=%h rw=%b ra=%h want a5/1/7",
                        WB_write_data, WB_RegWrite, WB_reg_write_addr);
    end
  endtask

  task automatic test_same_cycle_rw();
    store(8'h20, 8'h11);
    idle();
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b1; MEM_aluout = 8'h20; MEM_read_data_2 = 8'h22;
    tick();
    ref_mem[8'h20] = 8'h22;
    n_vec++;
    if (WB_read_data !== 8'h11) begin
      n_err++; $display("FAIL rw_same_cycle: got %h want 11", WB_read_data);
    end
    idle();
    MEM_MemRead = 1'b1; MEM_aluout = 8'h20;
    tick();
    n_vec++;
    if (WB_read_data !== 8'h22) begin
      n_err++; $display("FAIL rw_next_read: got %h want 22", WB_read_data);
    end
  endtask

  task automatic test_branch();
    idle();
    MEM_Branch = 1'b1; MEM_zr = 1'b1; MEM_branch_addr = 32'h40;
    #1;
    n_vec++;
    if (pc_redirect !== 1'b1 || pc_target !== 32'h40 || flush !== 1'b1) begin
      n_err++; $display("FAIL branch_taken: got %b/%h/%b want 1/40/1", pc_redirect, pc_target, flush);
    end
    MEM_BranchFlip = 1'b1;
    #1;
    n_vec++;
    if (pc_redirect !== 1'b0 || pc_target !== 32'h0 || flush !== 1'b0) begin
      n_err++; $display("FAIL branch_flip: got %b/%h/%b want 0/0/0", pc_redirect, pc_target, flush);
    end
    MEM_zr = 1'b0; MEM_ng = 1'b1; MEM_cr = 1'b1; MEM_ov = 1'b1;
    #1;
    n_vec++;
    if (pc_redirect !== 1'b1 || pc_target !== 32'h40) begin
      n_err++; $display("FAIL branch_flip_nz: got %b/%h want 1/40", pc_redirect, pc_target);
    end
  endtask

  task automatic test_priority();
    idle();
    MEM_Jump = 1'b1; MEM_jump_addr = 32'h80;
    MEM_Branch = 1'b1; MEM_zr = 1'b1; MEM_branch_addr = 32'h40;
    #1;
    n_vec++;
    if (pc_target !== 32'h80 || flush !== 1'b1 || pc_redirect !== 1'b1) begin
      n_err++; $display("FAIL jump_priority: got %h/%b/%b want 80/1/1", pc_target, flush, pc_redirect);
    end
  endtask

  task automatic test_reset_mid_store();
    store(8'h30, 8'h3C);
    idle();
    rst = 1'b1; MEM_MemWrite = 1'b1; MEM_aluout = 8'h30; MEM_read_data_2 = 8'hFF;
    MEM_RegWrite = 1'b1; MEM_Jump = 1'b1; MEM_jump_addr = 32'h99;
    #1;
    n_vec++;
    if (pc_redirect !== 1'b0 || pc_target !== 32'h0) begin
      n_err++; $display("FAIL rst_store_redirect: got %b/%h want 0/0", pc_redirect, pc_target);
    end
    tick();
    n_vec++;
    if ({WB_read_data, WB_aluout, WB_reg_write_addr, WB_RegWrite, WB_MemtoReg} !== '0) begin
      n_err++; $display("FAIL rst_store_wb: got alu=%h rw=%b want 0/0", WB_aluout, WB_RegWrite);
    end
    idle();
    MEM_MemRead = 1'b1; MEM_aluout = 8'h30; MEM_MemtoReg = 1'b1;
    tick();
    n_vec++;
    if (WB_write_data !== 8'h3C) begin
      n_err++; $display("FAIL rst_store_mem: got %h want 3c", WB_write_data);
    end
  endtask

  task automatic test_random();
    logic          e_redir;
    logic [AW-1:0] e_tgt;
    logic [DW-1:0] e_rd, e_alu;
    logic [AW-1:0] e_ra;
    logic          e_rw, e_m2r;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(15) == 0);
      MEM_aluout = 8'($urandom); MEM_read_data_2 = 8'($urandom);
      MEM_reg_write_addr = $urandom; MEM_branch_addr = $urandom; MEM_jump_addr = $urandom;
      {MEM_zr, MEM_ng, MEM_cr, MEM_ov} = 4'($urandom);
      {MEM_Branch, MEM_BranchFlip, MEM_MemRead, MEM_MemWrite} = 4'($urandom);
      {MEM_Jump, MEM_RegWrite, MEM_MemtoReg} = 3'($urandom);
      // A branch goes when zr differs from the flip sense; a jump always goes
      e_redir = !rst && (MEM_Jump || (MEM_Branch && (MEM_zr != MEM_BranchFlip)));
      e_tgt   = !e_redir ? '0 : (MEM_Jump ? MEM_jump_addr : MEM_branch_addr);
      if (rst) begin
        e_rd = '0; e_alu = '0; e_ra = '0; e_rw = 1'b0; e_m2r = 1'b0;
      end else begin
        e_rd  = MEM_MemRead ? ref_mem[MEM_aluout] : '0;
        e_alu = MEM_aluout; e_ra = MEM_reg_write_addr;
        e_rw  = MEM_RegWrite; e_m2r = MEM_MemtoReg;
      end
      #1;
      n_vec++;
      if (pc_redirect !== e_redir || flush !== e_redir || pc_target !== e_tgt) begin
        n_err++; $display("FAIL rand_redirect[%0d]: got %b/%b/%h want %b/%b/%h",
                          n, pc_redirect, flush, pc_target, e_redir, e_redir, e_tgt);
      end
      tick();
      if (!rst && MEM_MemWrite) ref_mem[MEM_aluout] = MEM_read_data_2;
      n_vec++;
      if (WB_read_data !== e_rd || WB_aluout !== e_alu || WB_reg_write_addr !== e_ra ||
          WB_RegWrite !== e_rw || WB_MemtoReg !== e_m2r ||
          WB_write_data !== (e_m2r ? e_rd : e_alu)) begin
        n_err++; $display("FAIL rand_wb[%0d]: got rd=%h alu=%h ra=%h rw=%b m2r=%b wd=%h want rd=%h alu=%h ra=%h rw=%b m2r=%b",
                          n, WB_read_data, WB_aluout, WB_reg_write_addr, WB_RegWrite, WB_MemtoReg,
                          WB_write_data, e_rd, e_alu, e_ra, e_rw, e_m2r);
      end
    end
    idle();
  endtask

`ifdef MEM_STAGE_STORE_CNT_EN
  task automatic test_store_count();
    idle(); rst = 1'b1; tick(); idle();
    store(8'h01, 8'h01); store(8'h02, 8'h02);
    idle(); rst = 1'b1; MEM_MemWrite = 1'b1; MEM_aluout = 8'h03; tick();
    store(8'h04, 8'h04);
    n_vec++;
    if (store_count !== 16'd3) begin
      n_err++; $display("FAIL store_count: got %0d want 3", store_count);
    end
    for (int i = 0; i < 65532; i++) store(8'hFF, 8'($urandom));
    n_vec++;
    if (store_count !== 16'hFFFF) begin
      n_err++; $display("FAIL store_count_max: got %h want ffff", store_count);
    end
    store(8'hFF, 8'h5E);
    n_vec++;
    if (store_count !== 16'h0000) begin
      n_err++; $display("FAIL store_count_wrap: got %h want 0000", store_count);
    end
    idle();
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_store_load();
    test_same_cycle_rw();
    test_branch();
    test_priority();
    test_reset_mid_store();
    test_random();
`ifdef MEM_STAGE_STORE_CNT_EN
    test_store_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
